seq_gen: RTL
============

# seq_gen

Serial pattern transmitter: emits a programmable PAT_W-bit pattern MSB-first, one bit per clock, repeated a programmable number of times with programmable idle gaps between repetitions. It is the stimulus/transmit end of the serial pattern link and drives bit-stream consumers such as sequence detectors. The default pattern is 110100.

## Interface
- PAT_W, 6, pattern width in bits (≥2)
- DEFAULT_PAT, 6'b110100, pattern register value after reset
- CNT_W, 8, width of the repetition count
- GAP_W, 4, width of the inter-repetition gap count
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low; one clock, no other clock domains
- start  in  1  request; sampled only in IDLE
- pat_in  in  PAT_W  pattern, latched on accepted start
- rep_in  in  CNT_W  repetitions, latched on accepted start; 0 = request rejected
- gap_in  in  GAP_W  idle cycles between repetitions, latched on accepted start
- stall  in  1  freezes SEND/GAP progress while high
- out  out  1  serial bit (registered)
- out_valid  out  1  high when out carries a pattern bit
- frame_start  out  1  one-cycle pulse coincident with the first bit of each repetition
- busy  out  1  high from the cycle after an accepted start through the last bit
- done  out  1  one-cycle pulse after the final bit

## Operation
- States: IDLE, SEND, GAP, DONE. Registers: pattern (PAT_W), bit index, repetitions remaining (CNT_W), gap counter (GAP_W).
- Reset (rst=0 at an edge): state IDLE; pattern=DEFAULT_PAT; counters 0; out, out_valid, frame_start, busy, done all 0. Reset during SEND/GAP/DONE aborts at that edge with no done pulse.
- IDLE: start=1 with rep_in≠0 latches pat_in/rep_in/gap_in and moves to SEND at bit index PAT_W-1. start with rep_in=0 is ignored: state stays IDLE and no output changes.
- SEND, stall=0: drive pattern[index], out_valid=1, and frame_start=1 when index=PAT_W-1. Decrement the index. After bit 0:
  - remaining>1 and gap>0: decrement remaining, load the gap counter, go to GAP.
  - remaining>1 and gap=0: decrement remaining, reload index PAT_W-1, stay in SEND (back-to-back repetitions).
  - remaining=1: go to DONE.
- GAP, stall=0: out=0, out_valid=0. Count down the gap. On expiry go to SEND with index PAT_W-1.
- stall=1 in SEND or GAP:
  - state, index and counters hold.
  - out holds its last value; out_valid=0 and frame_start=0.
  - stall has no effect in IDLE or DONE.
- DONE: one cycle with done=1, busy=0, out=0, out_valid=0, then IDLE.
- start is ignored outside IDLE, including the DONE cycle.
- The latched pattern persists after completion. A later start always re-latches pat_in.
- Counters never wrap: remaining is at least 1 in SEND; the gap counter is loaded only when gap_in>0.

## Timing
- All outputs are registered. When start is accepted at edge E, the first bit appears after E and is stable until E+1. busy rises with that bit.
- Unstalled frame (R repetitions, gap G): bits and gaps occupy PAT_W·R + G·(R-1) cycles. done pulses in the next cycle, so done appears at cycle PAT_W·R + G·(R-1) + 1 relative to the first-bit cycle 1.
- Each stall cycle adds exactly one cycle to the frame.
- busy is high in SEND and GAP only, and drops in the DONE cycle.
- The earliest next accepted start is the edge ending the cycle after DONE (in IDLE).

## Test plan
- Default pattern, rep_in=1, gap_in=0, start at cycle 0 -> out=1,1,0,1,0,0 with out_valid=1 on cycles 1–6; frame_start on cycle 1; done on cycle 7; busy=0 on cycle 7.
- rep_in=3, gap_in=2, pat_in=110100 -> three frames at cycles 1–6, 9–14 and 17–22, with out_valid=0 on cycles 7–8 and 15–16; frame_start on cycles 1, 9 and 17; done on cycle 23.
- rep_in=2, gap_in=0, pat_in=101011 -> 12 contiguous valid bits 101011101011; frame_start on cycles 1 and 7; done on cycle 13.
- stall held for 3 cycles after the third bit of 110100 -> out holds 0 and out_valid=0 for 3 cycles; the remaining bits 1,0,0 follow; done is delayed by 3 (cycle 10).
- start with rep_in=0 -> busy, out_valid and done remain 0. start pulsed during SEND -> ignored and the frame is unchanged.
- rst=0 at cycle 4 of a frame -> all outputs 0 at the next cycle with no done pulse; a subsequent start with rep_in=1 and pat_in=DEFAULT_PAT emits 110100 cleanly.

Source files
------------

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts out a latched pattern MSB-first, repeated
// rep_in times with gap_in idle cycles between repetitions.
module seq_gen #(
    parameter int unsigned       PAT_W       = 6,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = PAT_W'(6'b110100),
    parameter int unsigned       CNT_W       = 8,
    parameter int unsigned       GAP_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic [GAP_W-1:0] gap_in,
    input  logic             stall,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // state_q names the state whose output is currently on the pins
    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             out_d, out_valid_d, frame_start_d, busy_d, done_d;
    logic [IDX_W-1:0] idx_m1;

    assign idx_m1 = idx_q - IDX_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        idx_d         = idx_q;
        rem_d         = rem_q;
        gap_len_d     = gap_len_q;
        gcnt_d        = gcnt_q;
        out_d         = out;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (rep_in != '0)) begin
                    state_d       = S_SEND;
                    pat_d         = pat_in;
                    rem_d         = rep_in;
                    gap_len_d     = gap_in;
                    idx_d         = IDX_TOP;
                    out_d         = pat_in[PAT_W-1];
                    out_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end

            S_SEND: begin
                busy_d = 1'b1;
                if (stall) begin
                    state_d = S_SEND;
                end else if (idx_q != '0) begin
                    idx_d       = idx_m1;
                    out_d       = pat_q[idx_m1];
                    out_valid_d = 1'b1;
                end else if (rem_q > CNT_W'(1)) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (gap_len_q != '0) begin
                        state_d = S_GAP;
                        gcnt_d  = gap_len_q;
                        out_d   = 1'b0;
                    end else begin
                        idx_d         = IDX_TOP;
                        out_d         = pat_q[PAT_W-1];
                        out_valid_d   = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    out_d   = 1'b0;
                end
            end

            S_GAP: begin
                busy_d = 1'b1;
                // gcnt_q counts the gap cycles still to show, including this one
                if (!stall) begin
                    if (gcnt_q > GAP_W'(1)) begin
                        gcnt_d = gcnt_q - GAP_W'(1);
                    end else begin
                        gcnt_d        = '0;
                        state_d       = S_SEND;
                        idx_d         = IDX_TOP;
                        out_d         = pat_q[PAT_W-1];
                        out_valid_d   = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                out_d   = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                out_d   = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pat_q       <= DEFAULT_PAT;
            idx_q       <= '0;
            rem_q       <= '0;
            gap_len_q   <= '0;
            gcnt_q      <= '0;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            gap_len_q   <= gap_len_d;
            gcnt_q      <= gcnt_d;
            out         <= out_d;
            out_valid   <= out_valid_d;
            frame_start <= frame_start_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule
